// File: rtl/mux_arb_nx1_reg_pkg.sv
// Package: mux_arb_nx1_reg_pkg
// Purpose: shared definitions for the registered N:1 selector/arbiter.
//   mode_e   - runtime operating mode (direct select or round-robin).
//   wrap_idx - (base + step) folded once into the range [0, n).
// No ports (package).
package mux_arb_nx1_reg_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,  // channel chosen by sel
    MODE_RR  = 1'b1   // round-robin among valid inputs
  } mode_e;

  // base < n and step <= n are guaranteed by callers, so one
  // conditional subtraction replaces a modulo.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned step,
                                           input int unsigned n);
    int unsigned s;
    s = base + step;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/mux_arb_nx1_reg_rr_arbiter.sv
// Module: rr_arbiter_n
// Purpose: purely combinational round-robin grant. Searches req starting
//   at ptr+1 and wrapping N-1 -> 0; the first set request wins.
// Ports:
//   req     in  N      request vector (one bit per channel)
//   ptr     in  SEL_W  last granted channel (lowest priority this cycle)
//   gnt     out SEL_W  granted channel index (0 when nothing requests)
//   gnt_vld out 1      any request present
module rr_arbiter_n
  import mux_arb_nx1_reg_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_vld
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // Offset N wraps back to ptr itself, so the last-granted channel is
    // still chosen when it is the only requester.
    for (int k = 1; k <= N; k++) begin
      idx = SEL_W'(wrap_idx(32'(ptr), 32'(k), 32'(N)));
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign gnt_vld = |req;

endmodule

// File: rtl/mux_arb_nx1_reg.sv
// Module: mux_arb_nx1_reg
// Purpose: N-input, WIDTH-bit registered selector with valid/ready on each
//   input and on the output. Runtime mode picks direct select or
//   round-robin arbitration. One output register stage: 1-cycle latency,
//   one word per cycle when the consumer keeps out_ready high.
// Ports:
//   clk       in  1        rising-edge clock
//   rst_n     in  1        synchronous reset, active-low
//   mode      in  1        0 = direct select, 1 = round-robin
//   sel       in  SEL_W    channel index used in direct-select mode
//   in_data   in  N*WIDTH  packed inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid  in  N        per-channel valid
//   in_ready  out N        per-channel ready, at most one bit high
//   out_data  out WIDTH    registered output word
//   out_src   out SEL_W    channel the output word came from
//   out_valid out 1        out_data/out_src valid
//   out_ready in  1        consumer accepts when out_valid & out_ready
module mux_arb_nx1_reg
  import mux_arb_nx1_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  // Full index space of sel; padding bits read as "not valid" so an
  // out-of-range sel can never produce a grant.
  localparam int SEL_SPAN = 1 << SEL_W;

  logic [WIDTH-1:0]    chan [N];
  logic [SEL_SPAN-1:0] valid_ext;
  logic                sel_in_range;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    rr_gnt;
  logic                rr_gnt_vld;
  logic [SEL_W-1:0]    gnt;
  logic                gnt_vld;
  logic                load;

  assign valid_ext    = SEL_SPAN'(in_valid);
  assign sel_in_range = ({1'b0, sel} < (SEL_W + 1)'(N));

  rr_arbiter_n #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_vld (rr_gnt_vld)
  );

  always_comb begin
    gnt     = sel;
    gnt_vld = sel_in_range & valid_ext[sel];
    if (mode_e'(mode) == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_vld = rr_gnt_vld;
    end
  end

  // Gating with rst_n keeps inputs from being consumed in a reset cycle.
  assign load = rst_n & (~out_valid | out_ready);

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign chan[gi]     = in_data[gi*WIDTH +: WIDTH];
    assign in_ready[gi] = load & gnt_vld & (gnt == SEL_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(N - 1);  // channel 0 gets first priority
    end else if (load) begin
      if (gnt_vld) begin
        out_data  <= chan[gnt];
        out_src   <= gnt;
        out_valid <= 1'b1;
        if (mode_e'(mode) == MODE_RR) rr_ptr <= gnt;
      end else begin
        // Empty/draining with nothing to take: data and src keep last value.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_nx1_reg.sv
module tb_mux_arb_nx1_reg;

  localparam int W   = 32;
  localparam int NA  = 8;
  localparam int NB  = 6;
  localparam int SW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=8
  logic            rst_n;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [NA*W-1:0] in_data;
  logic [NA-1:0]   in_valid;
  logic [NA-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_src;
  logic            out_valid;
  logic            out_ready;

  // Instance B: N=6 (non power of two)
  logic            b_rst_n;
  logic            b_mode;
  logic [SW-1:0]   b_sel;
  logic [NB*W-1:0] b_in_data;
  logic [NB-1:0]   b_in_valid;
  logic [NB-1:0]   b_in_ready;
  logic [W-1:0]    b_out_data;
  logic [SW-1:0]   b_out_src;
  logic            b_out_valid;
  logic            b_out_ready;

  mux_arb_nx1_reg #(.WIDTH(W), .N(NA), .SEL_W(SW)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_arb_nx1_reg #(.WIDTH(W), .N(NB), .SEL_W(SW)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] src;
  } xfer_t;

  xfer_t sb_q[$];
  xfer_t mon_e;

  function automatic logic [W-1:0] word_a(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  task automatic fill_a();
    for (int i = 0; i < NA; i++) in_data[i*W +: W] = word_a(i);
  endtask

  // Scoreboard consumer: every output handshake on A pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: got data=%h src=%0d, required no word", out_data, out_src);
      end else begin
        mon_e = sb_q.pop_front();
        if (out_data !== mon_e.data || out_src !== mon_e.src)
          $display("FAIL sb_word: got data=%h src=%0d, required data=%h src=%0d",
                   out_data, out_src, mon_e.data, mon_e.src);
        else begin
          n_pass++;
          $display("xfer src=%0d data=%h", out_src, out_data);
        end
      end
    end
  end

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_valid);
      else n_pass++;
      n_checks++;
      if (out_data !== 32'h0) $display("FAIL rst_data: got %h, required 0", out_data);
      else n_pass++;
      n_checks++;
      if (in_ready !== 8'h00) $display("FAIL rst_ready: got %h, required 00", in_ready);
      else n_pass++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h01) $display("FAIL rst_first_grant: got %h, required 01", in_ready);
    else n_pass++;
    sb_q.push_back(xfer_t'{data: word_a(0), src: 3'd0});
    @(posedge clk); #1;
    in_valid = 8'h00;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_idle: got %b, required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_sel();
    @(posedge clk); #1;
    mode = 1'b0;
    sel  = 3'd5;
    in_data[5*W +: W] = 32'hDEAD_BEEF;
    in_valid = 8'h20;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h20) $display("FAIL sel_ready: got %h, required 20", in_ready);
    else n_pass++;
    sb_q.push_back(xfer_t'{data: 32'hDEAD_BEEF, src: 3'd5});
    @(posedge clk); #1;
    in_valid = 8'h00;
    @(negedge clk);
    n_checks++;
    if (out_data !== 32'hDEAD_BEEF || out_src !== 3'd5 || out_valid !== 1'b1)
      $display("FAIL sel_out: got data=%h src=%0d v=%b, required data=deadbeef src=5 v=1",
               out_data, out_src, out_valid);
    else n_pass++;
    fill_a();
  endtask

  task automatic test_rr_fair();
    logic [NA-1:0] exp_rdy;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    mode      = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_rdy = 8'h01 << (i % NA);
      n_checks++;
      if (in_ready !== exp_rdy) $display("FAIL rr_fair_ready[%0d]: got %h, required %h", i, in_ready, exp_rdy);
      else n_pass++;
      sb_q.push_back(xfer_t'{data: word_a(i % NA), src: SW'(i % NA)});
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rr_fair_valid[%0d]: got %b, required 1", i, out_valid);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    in_valid = 8'h00;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_rr_sparse();
    int            exp_tab [9] = '{0, 7, 0, 7, 4, 4, 4, 7, 0};
    logic [NA-1:0] v_tab   [9] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h10, 8'h10, 8'h10, 8'h81, 8'h81};
    logic [NA-1:0] exp_rdy;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_valid = v_tab[i];
      @(negedge clk);
      exp_rdy = 8'h01 << exp_tab[i];
      n_checks++;
      if (in_ready !== exp_rdy) $display("FAIL rr_sparse_ready[%0d]: got %h, required %h", i, in_ready, exp_rdy);
      else n_pass++;
      sb_q.push_back(xfer_t'{data: word_a(exp_tab[i]), src: SW'(exp_tab[i])});
    end
    @(posedge clk); #1;
    in_valid = 8'h00;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    mode = 1'b0;
    sel  = 3'd2;
    in_data[2*W +: W] = 32'h0000_1234;
    in_valid  = 8'h04;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h04) $display("FAIL bp_load_ready: got %h, required 04", in_ready);
    else n_pass++;
    sb_q.push_back(xfer_t'{data: 32'h0000_1234, src: 3'd2});
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_data[2*W +: W] = 32'h0000_5678;
      @(negedge clk);
      n_checks++;
      if (out_data !== 32'h0000_1234 || out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d]: got data=%h v=%b, required data=00001234 v=1", c, out_data, out_valid);
      else n_pass++;
      n_checks++;
      if (in_ready !== 8'h00) $display("FAIL bp_stall_ready[%0d]: got %h, required 00", c, in_ready);
      else n_pass++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h04) $display("FAIL bp_drain_ready: got %h, required 04", in_ready);
    else n_pass++;
    sb_q.push_back(xfer_t'{data: 32'h0000_5678, src: 3'd2});
    @(posedge clk); #1;
    in_valid = 8'h00;
    @(negedge clk);
    n_checks++;
    if (out_data !== 32'h0000_5678 || out_valid !== 1'b1)
      $display("FAIL bp_next_word: got data=%h v=%b, required data=00005678 v=1", out_data, out_valid);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b, required 0", out_valid);
    else n_pass++;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d words, required 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_sel_range();
    @(posedge clk); #1;
    b_rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_out_valid !== 1'b0) $display("FAIL b_rst_valid: got %b, required 0", b_out_valid);
    else n_pass++;
    @(posedge clk); #1;
    b_rst_n     = 1'b1;
    b_mode      = 1'b0;
    b_sel       = 3'd3;
    b_in_valid  = 6'h08;
    b_out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_in_ready !== 6'h08) $display("FAIL b_sel3_ready: got %h, required 08", b_in_ready);
    else n_pass++;
    @(posedge clk); #1;
    b_sel      = 3'd7;
    b_in_valid = 6'h3F;
    @(negedge clk);
    n_checks++;
    if (b_in_ready !== 6'h00) $display("FAIL b_oor_stall_ready: got %h, required 00", b_in_ready);
    else n_pass++;
    n_checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'h3333_3333 || b_out_src !== 3'd3)
      $display("FAIL b_held_word: got v=%b data=%h src=%0d, required v=1 data=33333333 src=3",
               b_out_valid, b_out_data, b_out_src);
    else n_pass++;
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b_in_ready !== 6'h00) $display("FAIL b_oor_ready: got %h, required 00", b_in_ready);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== 32'h3333_3333)
      $display("FAIL b_oor_drain: got v=%b data=%h, required v=0 data=33333333", b_out_valid, b_out_data);
    else n_pass++;
    @(posedge clk); #1;
    b_sel       = 3'd1;
    b_in_valid  = 6'h02;
    b_out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_in_ready !== 6'h02) $display("FAIL b_sel1_ready: got %h, required 02", b_in_ready);
    else n_pass++;
    @(posedge clk); #1;
    b_rst_n     = 1'b0;
    b_out_ready = 1'b1;
    b_in_valid  = 6'h3F;
    @(negedge clk);
    n_checks++;
    if (b_out_valid !== 1'b1 || b_in_ready !== 6'h00)
      $display("FAIL b_rst_mid: got v=%b rdy=%h, required v=1 rdy=00", b_out_valid, b_in_ready);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== 32'h0 || b_out_src !== 3'd0)
      $display("FAIL b_rst_clear: got v=%b data=%h src=%0d, required v=0 data=0 src=0",
               b_out_valid, b_out_data, b_out_src);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    fill_a();
    b_rst_n     = 1'b0;
    b_mode      = 1'b0;
    b_sel       = '0;
    b_in_valid  = '0;
    b_out_ready = 1'b1;
    for (int i = 0; i < NB; i++) b_in_data[i*W +: W] = 32'h1111_1111 * 32'(i);

    test_reset();
    test_sel();
    test_rr_fair();
    test_rr_sparse();
    test_backpressure();
    test_sel_range();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
